// File: rtl/mm_stream_hub_pkg.sv
`default_nettype none
// ============================================================================
// Module : mm_stream_pkg
// Desc   : Register offsets, ERR bit indices and status-field positions.
// Rev    : 1.0
// ============================================================================
package mm_stream_pkg;
    localparam logic [5:0] OFF_RX_DATA = 6'h00;
    localparam logic [5:0] OFF_RX_STAT = 6'h04;
    localparam logic [5:0] OFF_TX_STAT = 6'h08;
    localparam logic [5:0] OFF_ERR     = 6'h0C;
    localparam logic [5:0] OFF_TX_BASE = 6'h10;

    localparam int ERR_TX_FULL  = 0;
    localparam int ERR_RX_EMPTY = 1;
    localparam int ERR_W        = 2;

    localparam int RX_STAT_EMPTY = 16;
    localparam int RX_STAT_FULL  = 17;
    localparam int TX_STAT_EMPTY = 8;

    function automatic logic [3:0] word_of(input logic [5:0] off);
        return off[5:2];
    endfunction
endpackage
`default_nettype wire

// File: rtl/mm_stream_hub_if.sv
`default_nettype none
// ============================================================================
// Module : mm_stream_hub_if
// Desc   : CPU register port plus inbound/outbound stream bundle.
// Rev    : 1.0
// ============================================================================
interface mm_stream_hub_if #(
    parameter int DATA_W = 32,
    parameter int NUM_TX = 4
);
    logic                     sel_i;
    logic [5:0]               addr_i;
    logic [DATA_W-1:0]        wdata_i;
    logic [3:0]               we_i;
    logic                     re_i;
    logic [DATA_W-1:0]        rdata_o;
    logic                     stall_o;
    logic [DATA_W-1:0]        rx_data_i;
    logic                     rx_valid_i;
    logic                     rx_ready_o;
    logic [NUM_TX*DATA_W-1:0] tx_data_o;
    logic [NUM_TX-1:0]        tx_valid_o;
    logic [NUM_TX-1:0]        tx_ready_i;
    logic                     irq_o;

    modport slave (
        input  sel_i, addr_i, wdata_i, we_i, re_i, rx_data_i, rx_valid_i, tx_ready_i,
        output rdata_o, stall_o, rx_ready_o, tx_data_o, tx_valid_o, irq_o
    );
    modport master (
        output sel_i, addr_i, wdata_i, we_i, re_i, rx_data_i, rx_valid_i, tx_ready_i,
        input  rdata_o, stall_o, rx_ready_o, tx_data_o, tx_valid_o, irq_o
    );
endinterface
`default_nettype wire

// File: rtl/mm_stream_hub_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Desc   : First-word-fall-through FIFO; push refused when full at cycle start.
// Rev    : 1.0
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  wire logic                     clk_i,
    input  wire logic                     reset_i,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [DATA_W-1:0]        wdata,
    output logic      [DATA_W-1:0]        rdata,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/mm_stream_hub.sv
`default_nettype none
// ============================================================================
// Module : mm_stream_hub
// Desc   : Memory-mapped CPU port feeding NUM_TX outbound FIFOs and one RX FIFO.
// Rev    : 1.0
// ============================================================================
module mm_stream_hub
    import mm_stream_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_TX   = 4,
    parameter int DEPTH    = 8,
    parameter int BLOCKING = 1
) (
    input  wire logic       clk_i,
    input  wire logic       reset_i,
    mm_stream_hub_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]             w_word;
    logic                   w_wr;
    logic                   w_rd_rx;
    logic [NUM_TX-1:0]      w_tx_hit;
    logic [NUM_TX-1:0]      w_tx_push;
    logic [NUM_TX-1:0]      w_tx_full;
    logic [NUM_TX-1:0]      w_tx_empty;
    logic [NUM_TX*CW-1:0]   w_tx_count;
    logic [NUM_TX*DATA_W-1:0] w_tx_data;
    logic                   w_tx_full_hit;
    logic                   w_rx_empty_rd;
    logic                   w_stall;
    logic                   w_rx_full;
    logic                   w_rx_empty;
    logic                   w_rx_pop;
    logic                   w_rx_push;
    logic [DATA_W-1:0]      w_rx_head;
    logic [CW-1:0]          w_rx_count;
    logic [ERR_W-1:0]       r_err;
    logic [ERR_W-1:0]       w_err_set;
    logic [ERR_W-1:0]       w_err_clr;
    logic                   r_run;
    logic [31:0]            w_rd32;
    logic [31:0]            w_rx_stat;
    logic [31:0]            w_tx_stat;
    logic                   w_unused;

    assign w_word  = bus.addr_i[5:2];
    assign w_wr    = bus.sel_i & (|bus.we_i);
    assign w_rd_rx = bus.sel_i & bus.re_i & (w_word == word_of(OFF_RX_DATA));

    generate
        for (genvar c = 0; c < NUM_TX; c++) begin : g_tx
            assign w_tx_hit[c]  = w_wr & (w_word == word_of(OFF_TX_BASE) + 4'(c));
            assign w_tx_push[c] = w_tx_hit[c] & ~w_stall;
            sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
                .clk_i,
                .reset_i,
                .push  (w_tx_push[c]),
                .pop   (bus.tx_ready_i[c]),
                .wdata (bus.wdata_i),
                .rdata (w_tx_data[c*DATA_W +: DATA_W]),
                .full  (w_tx_full[c]),
                .empty (w_tx_empty[c]),
                .count (w_tx_count[c*CW +: CW])
            );
        end
    endgenerate

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk_i,
        .reset_i,
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .wdata (bus.rx_data_i),
        .rdata (w_rx_head),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    // A stalled access is held off entirely, so neither its push nor its pop lands.
    assign w_tx_full_hit = |(w_tx_hit & w_tx_full);
    assign w_rx_empty_rd = w_rd_rx & w_rx_empty;
    assign w_stall       = (BLOCKING != 0) ? (w_tx_full_hit | w_rx_empty_rd) : 1'b0;
    assign w_rx_pop      = w_rd_rx & ~w_stall;
    assign w_rx_push     = bus.rx_valid_i & bus.rx_ready_o;

    assign bus.stall_o    = w_stall;
    assign bus.rx_ready_o = r_run & ~w_rx_full;
    assign bus.tx_valid_o = ~w_tx_empty;
    assign bus.tx_data_o  = w_tx_data;
    assign bus.irq_o      = ~w_rx_empty | (|r_err);

    always_comb begin
        w_err_set               = '0;
        w_err_set[ERR_TX_FULL]  = (BLOCKING == 0) && w_tx_full_hit;
        w_err_set[ERR_RX_EMPTY] = (BLOCKING == 0) && w_rx_empty_rd;
    end
    assign w_err_clr = (w_wr && (w_word == word_of(OFF_ERR))) ? bus.wdata_i[ERR_W-1:0] : '0;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_err <= '0;
            r_run <= 1'b0;
        end else begin
            r_err <= (r_err & ~w_err_clr) | w_err_set;
            r_run <= 1'b1;
        end
    end

    always_comb begin
        w_rx_stat                          = '0;
        w_rx_stat[CW-1:0]                  = w_rx_count;
        w_rx_stat[RX_STAT_EMPTY]           = w_rx_empty;
        w_rx_stat[RX_STAT_FULL]            = w_rx_full;
        w_tx_stat                          = '0;
        w_tx_stat[NUM_TX-1:0]              = w_tx_full;
        w_tx_stat[TX_STAT_EMPTY +: NUM_TX] = w_tx_empty;
        w_rd32                             = '0;
        case (w_word)
            word_of(OFF_RX_DATA): w_rd32[DATA_W-1:0] = w_rx_empty ? '0 : w_rx_head;
            word_of(OFF_RX_STAT): w_rd32 = w_rx_stat;
            word_of(OFF_TX_STAT): w_rd32 = w_tx_stat;
            word_of(OFF_ERR):     w_rd32[ERR_W-1:0] = r_err;
            default:              w_rd32 = '0;
        endcase
    end
    assign bus.rdata_o = w_rd32[DATA_W-1:0];

    assign w_unused = ^{bus.addr_i[1:0], w_tx_count};
endmodule
`default_nettype wire

// File: tb/tb_mm_stream_hub.sv
`default_nettype none
// ============================================================================
// Module : tb_mm_stream_hub
// Desc   : Blocking and non-blocking hubs checked against queue-based models.
// Rev    : 1.0
// ============================================================================
module tb_mm_stream_hub;
    localparam int DW = 32;
    localparam int NT = 4;
    localparam int DP = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mm_stream_hub_if #(.DATA_W(DW), .NUM_TX(NT)) ifb ();
    mm_stream_hub_if #(.DATA_W(DW), .NUM_TX(NT)) ifn ();

    mm_stream_hub #(.DATA_W(DW), .NUM_TX(NT), .DEPTH(DP), .BLOCKING(1)) dut_b (
        .clk_i(clk), .reset_i(rst_n), .bus(ifb));
    mm_stream_hub #(.DATA_W(DW), .NUM_TX(NT), .DEPTH(DP), .BLOCKING(0)) dut_n (
        .clk_i(clk), .reset_i(rst_n), .bus(ifn));

    logic          sel  [2];
    logic [5:0]    addr [2];
    logic [31:0]   wd   [2];
    logic [3:0]    we   [2];
    logic          re   [2];
    logic          rxv  [2];
    logic [31:0]   rxd  [2];
    logic [NT-1:0] txr  [2];

    assign ifb.sel_i = sel[0];  assign ifb.addr_i = addr[0]; assign ifb.wdata_i = wd[0];
    assign ifb.we_i  = we[0];   assign ifb.re_i   = re[0];   assign ifb.rx_valid_i = rxv[0];
    assign ifb.rx_data_i = rxd[0]; assign ifb.tx_ready_i = txr[0];
    assign ifn.sel_i = sel[1];  assign ifn.addr_i = addr[1]; assign ifn.wdata_i = wd[1];
    assign ifn.we_i  = we[1];   assign ifn.re_i   = re[1];   assign ifn.rx_valid_i = rxv[1];
    assign ifn.rx_data_i = rxd[1]; assign ifn.tx_ready_i = txr[1];

    // Reference model: one queue per FIFO, sticky error bits, "out of reset" flag.
    logic [31:0] txq [2*NT][$];
    logic [31:0] rxq [2][$];
    logic [31:0] tx0_out [2][$];
    logic [1:0]  err [2];
    logic        run;
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] o_rdata(int m); return (m == 0) ? ifb.rdata_o : ifn.rdata_o; endfunction
    function automatic logic o_stall(int m); return (m == 0) ? ifb.stall_o : ifn.stall_o; endfunction
    function automatic logic o_irq(int m); return (m == 0) ? ifb.irq_o : ifn.irq_o; endfunction
    function automatic logic o_rxr(int m); return (m == 0) ? ifb.rx_ready_o : ifn.rx_ready_o; endfunction
    function automatic logic [NT-1:0] o_txv(int m); return (m == 0) ? ifb.tx_valid_o : ifn.tx_valid_o; endfunction
    function automatic logic [31:0] o_txd(int m, int c);
        logic [NT*DW-1:0] v;
        v = (m == 0) ? ifb.tx_data_o : ifn.tx_data_o;
        return v[c*DW +: DW];
    endfunction

    task automatic chk(string tag, int m, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, m, obs, exp);
        end
    endtask

    task automatic idle(int m);
        sel[m] = 1'b0; addr[m] = '0; wd[m] = '0; we[m] = '0; re[m] = 1'b0;
        rxv[m] = 1'b0; rxd[m] = '0; txr[m] = '0;
    endtask

    task automatic cpu(int m, logic [5:0] a, logic [31:0] d, logic w, logic r);
        sel[m] = 1'b1; addr[m] = a; wd[m] = d; we[m] = w ? 4'hF : 4'h0; re[m] = r;
    endtask

    // One clock: compare every output against the model, then advance the model.
    task automatic tick();
        #1;
        for (int m = 0; m < 2; m++) begin
            int w, tgt, rx_n;
            bit wr, rd_rx, tx_full_hit, stall, rx_cap;
            logic [31:0] exp_rd, v;
            logic [NT-1:0] exp_v;
            w     = int'(addr[m][5:2]);
            wr    = sel[m] && (we[m] != 4'h0);
            tgt   = (wr && w >= 4 && w < 4 + NT) ? w - 4 : -1;
            tx_full_hit = 1'b0;
            if (tgt >= 0) tx_full_hit = (txq[m*NT+tgt].size() == DP);
            rd_rx = sel[m] && re[m] && (w == 0);
            rx_n  = rxq[m].size();
            stall = (m == 0) && (tx_full_hit || (rd_rx && rx_n == 0));
            chk("stall", m, 32'(o_stall(m)), 32'(stall));
            chk("irq", m, 32'(o_irq(m)), 32'((rx_n != 0) || (err[m] != 2'b00)));
            chk("rx_ready", m, 32'(o_rxr(m)), 32'(run && rx_n < DP));
            for (int c = 0; c < NT; c++) exp_v[c] = (txq[m*NT+c].size() != 0);
            chk("tx_valid", m, 32'(o_txv(m)), 32'(exp_v));
            for (int c = 0; c < NT; c++)
                if (exp_v[c]) chk("tx_data", m, o_txd(m, c), txq[m*NT+c][0]);
            if (sel[m] && re[m]) begin
                exp_rd = '0;
                case (w)
                    0: exp_rd = (rx_n != 0) ? rxq[m][0] : 32'h0;
                    1: begin exp_rd = 32'(rx_n); exp_rd[16] = (rx_n == 0); exp_rd[17] = (rx_n == DP); end
                    2: for (int c = 0; c < NT; c++) begin
                           exp_rd[c]     = (txq[m*NT+c].size() == DP);
                           exp_rd[8 + c] = (txq[m*NT+c].size() == 0);
                       end
                    3: exp_rd = {30'b0, err[m]};
                    default: exp_rd = '0;
                endcase
                chk("rdata", m, o_rdata(m), exp_rd);
            end
            for (int c = 0; c < NT; c++)
                if (txr[m][c] && txq[m*NT+c].size() != 0) begin
                    v = txq[m*NT+c].pop_front();
                    if (c == 0) tx0_out[m].push_back(v);
                end
            if (tgt >= 0 && !stall) begin
                if (!tx_full_hit) txq[m*NT+tgt].push_back(wd[m]);
                else              err[m][0] = 1'b1;
            end
            rx_cap = rxv[m] && run && (rx_n < DP);
            if (wr && w == 3) err[m] = err[m] & ~wd[m][1:0];
            if (rd_rx && !stall) begin
                if (rx_n != 0) void'(rxq[m].pop_front());
                else           err[m][1] = 1'b1;
            end
            if (rx_cap) rxq[m].push_back(rxd[m]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check();
        for (int m = 0; m < 2; m++) begin idle(m); cpu(m, 6'h04, 32'h0, 1'b0, 1'b1); end
        #2 rst_n = 1'b0;
        #1;
        run = 1'b0;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NT; c++) txq[m*NT+c].delete();
            rxq[m].delete(); tx0_out[m].delete(); err[m] = 2'b00;
            chk("rst_rx_stat", m, o_rdata(m), 32'h0001_0000);
            chk("rst_tx_valid", m, 32'(o_txv(m)), 32'h0);
            chk("rst_rx_ready", m, 32'(o_rxr(m)), 32'h0);
            chk("rst_stall", m, 32'(o_stall(m)), 32'h0);
            chk("rst_irq", m, 32'(o_irq(m)), 32'h0);
            addr[m] = 6'h0C;
        end
        #1;
        for (int m = 0; m < 2; m++) chk("rst_err", m, o_rdata(m), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b1;
        for (int m = 0; m < 2; m++) idle(m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k [2];
        bit acc [2];
        run = 1'b0;
        for (int m = 0; m < 2; m++) begin idle(m); err[m] = 2'b00; end
        repeat (2) @(posedge clk);
        #1;
        reset_check();

        // Reset mid-stream: 3 words parked in TX0 and 2 in RX.
        for (int i = 0; i < 3; i++) begin
            for (int m = 0; m < 2; m++) begin
                cpu(m, 6'h10, 32'hC0DE_0000 + 32'(i), 1'b1, 1'b0);
                rxv[m] = (i < 2); rxd[m] = 32'h55 + 32'(i);
            end
            tick();
        end
        for (int m = 0; m < 2; m++) idle(m);
        tick();
        reset_check();

        // TX2 latency with ready held high.
        for (int m = 0; m < 2; m++) begin txr[m] = 4'b0100; cpu(m, 6'h18, 32'hA5A5_0001, 1'b1, 1'b0); end
        tick();
        for (int m = 0; m < 2; m++) begin sel[m] = 1'b0; we[m] = 4'h0; end
        tick(); tick();
        for (int m = 0; m < 2; m++) idle(m);

        // Nine writes into TX0 with no ready.
        for (int i = 1; i <= 9; i++) begin
            for (int m = 0; m < 2; m++) cpu(m, 6'h10, 32'(i), 1'b1, 1'b0);
            tick();
        end
        idle(1);
        tick();
        txr[0][0] = 1'b1; tick();
        txr[0][0] = 1'b0; tick();
        idle(0);
        for (int m = 0; m < 2; m++) cpu(m, 6'h0C, 32'h0, 1'b0, 1'b1);
        tick();
        for (int m = 0; m < 2; m++) cpu(m, 6'h0C, 32'h1, 1'b1, 1'b0);
        tick();
        for (int m = 0; m < 2; m++) cpu(m, 6'h0C, 32'h0, 1'b0, 1'b1);
        tick();
        for (int m = 0; m < 2; m++) begin idle(m); txr[m] = 4'b0001; end
        repeat (10) tick();
        for (int m = 0; m < 2; m++) begin
            int n;
            n = (m == 0) ? 9 : 8;
            chk("tx0_count", m, 32'(tx0_out[m].size()), 32'(n));
            for (int i = 0; i < n && i < tx0_out[m].size(); i++)
                chk("tx0_order", m, tx0_out[m][i], 32'(i + 1));
            idle(m);
        end

        // RX fill, overflow attempt, drain, and one read past empty.
        for (int i = 0; i < 9; i++) begin
            for (int m = 0; m < 2; m++) begin rxv[m] = 1'b1; rxd[m] = (i < 8) ? 32'h10 + 32'(i) : 32'h99; end
            tick();
        end
        for (int m = 0; m < 2; m++) begin idle(m); cpu(m, 6'h04, 32'h0, 1'b0, 1'b1); end
        tick();
        for (int m = 0; m < 2; m++) addr[m] = 6'h00;
        repeat (9) tick();
        for (int m = 0; m < 2; m++) addr[m] = 6'h0C;
        tick();
        for (int m = 0; m < 2; m++) cpu(m, 6'h0C, 32'h2, 1'b1, 1'b0);
        tick();

        // Full RX with simultaneous pop and beat, then 3*DEPTH words through.
        for (int m = 0; m < 2; m++) begin idle(m); rxv[m] = 1'b1; k[m] = 0; end
        for (int i = 0; i < 4 * DP; i++) begin
            for (int m = 0; m < 2; m++) begin
                rxd[m] = 32'h200 + 32'(k[m]);
                if (i >= DP) cpu(m, 6'h00, 32'h0, 1'b0, 1'b1);
                acc[m] = rxq[m].size() < DP || (i >= DP && rxq[m].size() != 0 && 1'b0);
            end
            tick();
            for (int m = 0; m < 2; m++) if (acc[m]) k[m]++;
        end
        for (int m = 0; m < 2; m++) begin idle(m); cpu(m, 6'h00, 32'h0, 1'b0, 1'b1); end
        repeat (DP) tick();
        for (int m = 0; m < 2; m++) cpu(m, 6'h04, 32'h0, 1'b0, 1'b1);
        tick();

        // Random traffic on both hubs.
        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < 2; m++) begin
                sel[m]  = ($urandom_range(0, 3) != 0);
                addr[m] = {4'($urandom_range(0, 11)), 2'($urandom_range(0, 3))};
                wd[m]   = $urandom;
                we[m]   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                re[m]   = ($urandom_range(0, 1) != 0);
                rxv[m]  = ($urandom_range(0, 1) != 0);
                rxd[m]  = $urandom;
                txr[m]  = NT'($urandom) & NT'($urandom);
            end
            tick();
        end
        reset_check();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mm_stream_hub.md
Name: mm_stream_hub

Overview:
- Parametrised successor to the single-channel AXI-style master/slave pair plus address decoder: one memory-mapped CPU-side register port feeding NUM_TX buffered outbound stream channels and draining one buffered inbound stream channel.
- Sits between the CPU data port (via the system address decoder, which supplies sel_i) and the external stream interfaces.
- Adds per-channel FIFOs, a blocking or non-blocking mode, sticky error flags and an interrupt, none of which the previous pair had.

Parameters:
- DATA_W, 32, stream and register data width (multiple of 8, ≤ 32 for status-field packing)
- NUM_TX, 4, outbound channel count (1..8)
- DEPTH, 8, entries per FIFO (power of two, ≥ 2)
- BLOCKING, 1, 1 = stall CPU on full/empty access; 0 = drop or return zero and set an error flag

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-low reset
- sel_i  in  1  address decoder selects this block
- addr_i  in  6  byte offset within the block; bits [1:0] ignored
- wdata_i  in  DATA_W  CPU write data
- we_i  in  4  CPU byte write enables; any nonzero value is treated as a full-word write
- re_i  in  1  CPU load strobe for the current address
- rdata_o  out  DATA_W  register read data, combinational
- stall_o  out  1  external stall to the CPU, combinational
- rx_data_i  in  DATA_W  inbound stream data
- rx_valid_i  in  1  inbound valid
- rx_ready_o  out  1  inbound ready
- tx_data_o  out  NUM_TX*DATA_W  outbound data; channel c occupies [c*DATA_W +: DATA_W]
- tx_valid_o  out  NUM_TX  outbound valid
- tx_ready_i  in  NUM_TX  outbound ready
- irq_o  out  1  interrupt, level

Behaviour:
- Register map (word offsets):
  - 0x00 RX_DATA (R, pops)
  - 0x04 RX_STAT (R): [15:0] RX count, [16] empty, [17] full
  - 0x08 TX_STAT (R): [NUM_TX-1:0] full bits, [15:8] empty bits
  - 0x0C ERR (R/W1C): [0] TX write to full channel, [1] RX read while empty
  - 0x10 + 4*c TX_DATA[c] (W, pushes)
- Unmapped reads return 0; unmapped writes are ignored.
- Reset (reset_i low, asynchronous): all FIFOs empty; ERR = 0; tx_valid_o = 0; rx_ready_o = 0 while reset is asserted, then 1 from the first cycle after release; stall_o = 0; irq_o = 0; rdata_o reflects the empty state.
- Reset mid-transfer discards all buffered data with no partial beat.
- FIFO: first-word-fall-through; head data is driven combinationally from storage; valid = not empty.
- Push is accepted iff count < DEPTH at the start of the cycle, even when a pop occurs in the same cycle.
- Simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- TX channel c:
  - Push on the rising edge when sel_i, |we_i, addr_i = TX_DATA[c], the channel is not full and stall_o = 0.
  - Beat leaves when tx_valid_o[c] & tx_ready_i[c].
  - Latency: a written word is visible on tx_valid_o[c] the cycle after the write edge.
  - Channels are fully independent; a full channel never blocks another.
- RX:
  - rx_ready_o = not full.
  - A beat is captured when rx_valid_i & rx_ready_o.
  - The CPU pops on the edge when sel_i, re_i, addr_i = RX_DATA, the FIFO is not empty and stall_o = 0.
  - rdata_o at RX_DATA shows the head combinationally in the same cycle.
- BLOCKING = 1:
  - stall_o = sel_i & ((|we_i & targeted TX full) | (re_i & addr_i = RX_DATA & RX empty)).
  - Stall persists until the condition clears; the access then completes in that cycle.
- BLOCKING = 0:
  - stall_o = 0 always.
  - A write to a full TX channel is dropped and sets ERR[0].
  - An RX_DATA read while empty returns 0 and sets ERR[1].
- ERR handling: W1C; if a set event and a clear hit the same bit in the same cycle, set wins.
- irq_o = RX not empty | (|ERR), combinational from registered state.

Decomposition:
- Shared package mm_stream_pkg holds the register offset constants, the ERR bit indices and the STAT field positions.
- Sub-module sync_fifo (parameters DATA_W, DEPTH; ports push, pop, wdata, rdata, full, empty, count) is instantiated NUM_TX+1 times.

Test Plan:
- Reset mid-stream with 3 words in TX0 and 2 in RX -> all tx_valid_o = 0; RX_STAT = 0x0001_0000; ERR = 0; irq_o = 0.
- Write 0xA5A5_0001 to TX_DATA[2] with tx_ready_i[2] = 1 -> tx_valid_o[2] high exactly one cycle later with data 0xA5A5_0001; the other channels stay idle.
- BLOCKING = 1, DEPTH = 8: 9 writes to TX0 with tx_ready_i[0] = 0 -> stall_o rises on the 9th write; raising tx_ready_i for one cycle releases the stall and the 9th word is accepted; output order is 1..9.
- BLOCKING = 0: same stimulus -> 9th word dropped; ERR = 0x1; irq_o = 1; writing 0x1 to ERR clears it.
- Drive 8 RX beats 0x10..0x17 -> rx_ready_o drops after the 8th; RX_STAT[17] = 1; 8 RX_DATA reads return 0x10..0x17 in order; a 9th read stalls (BLOCKING = 1) or returns 0 and sets ERR[1] (BLOCKING = 0).
- Simultaneous CPU pop and RX beat on a full RX FIFO, plus pointer wrap over 3×DEPTH words -> no loss or duplication; count stays consistent.
